uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling
//
// Recovers bytes from an asynchronous, idle-high serial line.  The line is
// brought into the clk_50M domain through a two-flop synchroniser.  A start
// edge is confirmed at the middle of the start bit.  Each following bit is
// then sampled one full bit period later.
//
// Parameters
//   CLKS_PER_BIT  clk_50M cycles per bit (legal 16..8191)
//   CNT_W         bit-period counter width; must hold CLKS_PER_BIT-1
//
// Ports
//   clk_50M    in   system clock
//   rst_n      in   asynchronous active-low reset
//   uart_rxd   in   asynchronous serial line, idle high
//   rx_data    out  [7:0] last correctly framed byte (first bit in bit 0)
//   rx_valid   out  one-cycle strobe, rx_data updated on the same cycle
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   busy       out  high whenever the receiver is not idle
//
// Output handshake: rx_valid and frame_err are pure strobes with no ready.
// The consumer must capture rx_data on the cycle rx_valid is high.  rx_data
// then holds that value until the next good frame.  The two strobes are
// mutually exclusive, and neither is ever high on two consecutive cycles.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    // Terminal counts, taken at the last cycle of the half/full bit period.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             rxd_m;
    logic             rxd_s;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser.  Both flops reset to the idle (high) level so
    // that leaving reset never looks like a start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM with registered outputs.
    //
    // The counter restarts on every state change.  IDLE and WAIT_HI never
    // look at the counter, so it is held at zero there.  This keeps it from
    // wrapping while the line sits idle or in a break for a long time.
    //
    // busy is registered together with the state, so it equals
    // (state != IDLE) and cannot glitch.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            clk_cnt   <= clk_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            // Line went back high before mid start bit:
                            // treat it as noise, with no output activity.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        // LSB arrives first, so shift right and insert at
                        // the MSB.  After 8 samples, bit 0 is the first bit.
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rxd_s) begin
                            // Return to IDLE at mid stop bit so a start
                            // bit right behind it is still caught.
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end
                end

                WAIT_HI: begin
                    // A held-low break is reported once, not as a stream
                    // of frames.  Wait for the line to come back high.
                    clk_cnt <= '0;
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx
//
// The receiver runs with a short bit period so many frames fit in a short
// run.  A serial driver task plays the transmitter, and the expected
// receiver events are pushed into exp_q.  Each queue entry is
// {frame_err, rx_data}.  A negedge monitor pops one entry for every strobe
// the DUT raises and compares the two.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB   = 64;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = 13;
    localparam int LAT   = 2 + HALF + 9 * CPB;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // ---------------- clock / reset ----------------
    always #10 clk_50M = ~clk_50M;

    int unsigned cyc = 0;
    always @(posedge clk_50M) cyc++;

    initial begin
        #(95000 * 20);
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [8:0]  exp_q[$];
    logic [7:0]  last_good = 8'h00;
    int unsigned exp_pulses = 0;
    int unsigned pulse_cnt  = 0;
    int unsigned last_pulse_cyc = 0;
    int unsigned tx_start_cyc   = 0;
    logic        prev_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame whose stop bit is high delivers its byte.
    // Otherwise it reports a framing error and the last good byte stays.
    task automatic model_frame(input logic [7:0] d, input logic stop_lvl);
        if (stop_lvl) begin
            last_good = d;
            exp_q.push_back({1'b0, d});
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        exp_pulses++;
    endtask

    always @(negedge clk_50M) begin
        logic [8:0] e;
        if (rst_n) begin
            if (rx_valid || frame_err) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                check("strobe_one_cycle", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h expected no strobe",
                             rx_valid, frame_err, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_event", {23'd0, frame_err, rx_data}, {23'd0, e});
                end
            end
            prev_pulse = rx_valid | frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    // ---------------- driver tasks (all start and end on a negedge) -------
    task automatic send_frame(input logic [7:0] d, input int p, input logic stop_lvl);
        logic [9:0] bits;
        bits = {stop_lvl, d, 1'b0};
        tx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (p) @(negedge clk_50M);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic idle_line(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk_50M);
    endtask

    // Bounded wait for every expected strobe to appear.  Afterwards the
    // receiver must be idle.
    task automatic settle(input string name);
        for (int k = 0; k < 12 * CPB && exp_q.size() != 0; k++) @(negedge clk_50M);
        check({name, "_pending"}, exp_q.size(), 32'd0);
        repeat (4) @(negedge clk_50M);
        check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] data;
        int         period;
        logic       stop_lvl;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned p0;
        int          lat;

        vecs[0] = '{8'h3C, 64, 1'b0, 8, 1'b1, 8'hA5};  // framing error, data held
        vecs[1] = '{8'h5A, 64, 1'b1, 0, 1'b0, 8'h5A};
        vecs[2] = '{8'h00, 63, 1'b1, 3, 1'b0, 8'h00};
        vecs[3] = '{8'hFF, 65, 1'b1, 0, 1'b0, 8'hFF};
        vecs[4] = '{8'h55, 62, 1'b1, 5, 1'b0, 8'h55};  // fast edge of tolerance
        vecs[5] = '{8'hAA, 66, 1'b1, 0, 1'b0, 8'hAA};  // slow edge of tolerance
        vecs[6] = '{8'h01, 64, 1'b0, 6, 1'b1, 8'hAA};
        vecs[7] = '{8'h80, 64, 1'b1, 2, 1'b0, 8'h80};

        // ---- reset values ----
        repeat (3) @(negedge clk_50M);
        check("rst_rx_data",   {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle_line(5);

        // ---- loopback 0xA5 with latency ----
        p0 = pulse_cnt;
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, CPB, 1'b1);
        settle("loopback");
        lat = int'(last_pulse_cyc) - int'(tx_start_cyc);
        check("latency_window", {31'd0, (lat >= LAT - 2) && (lat <= LAT + 2)}, 32'd1);
        check("loopback_pulses", pulse_cnt - p0, 32'd1);
        check("loopback_data", {24'd0, rx_data}, 32'h0000_00A5);

        // ---- table ----
        for (int i = 0; i < 8; i++) begin
            p0 = pulse_cnt;
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_data});
            exp_pulses++;
            if (vecs[i].stop_lvl) last_good = vecs[i].data;
            send_frame(vecs[i].data, vecs[i].period, vecs[i].stop_lvl);
            idle_line(vecs[i].gap);
            settle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, 32'd1);
            check($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
        end

        // ---- glitch shorter than half a bit ----
        p0 = pulse_cnt;
        uart_rxd = 1'b0;
        repeat (10) @(negedge clk_50M);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk_50M);
        idle_line(3 * CPB);
        check("glitch_busy_idle", {31'd0, busy}, 32'd0);
        check("glitch_no_strobe", pulse_cnt - p0, 32'd0);
        check("glitch_data_held", {24'd0, rx_data}, {24'd0, last_good});

        // ---- break: 20 bit times low ----
        p0 = pulse_cnt;
        model_frame(8'h00, 1'b0);
        uart_rxd = 1'b0;
        repeat (20 * CPB) @(negedge clk_50M);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        check("break_one_err", pulse_cnt - p0, 32'd1);
        check("break_pending", exp_q.size(), 32'd0);
        idle_line(5);
        check("break_busy_release", {31'd0, busy}, 32'd0);
        idle_line(2 * CPB);
        check("break_no_more", pulse_cnt - p0, 32'd1);

        // ---- back-to-back, no idle gap, at slow and fast rates ----
        for (int r = 0; r < 2; r++) begin
            int pp;
            pp = (r == 0) ? 63 : 65;
            p0 = pulse_cnt;
            model_frame(8'h00, 1'b1);
            model_frame(8'hFF, 1'b1);
            send_frame(8'h00, pp, 1'b1);
            send_frame(8'hFF, pp, 1'b1);
            settle($sformatf("b2b%0d", r));
            check($sformatf("b2b%0d_pulses", r), pulse_cnt - p0, 32'd2);
            check($sformatf("b2b%0d_data", r), {24'd0, rx_data}, 32'h0000_00FF);
        end

        // ---- reset during data bit 4 ----
        p0 = pulse_cnt;
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hE7, 1'b0};
            for (int i = 0; i < 5; i++) begin
                uart_rxd = bits[i];
                repeat (CPB) @(negedge clk_50M);
            end
            uart_rxd = bits[5];
            repeat (CPB / 2) @(negedge clk_50M);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_rx_data",   {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid",  {31'd0, rx_valid}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check("midrst_busy",      {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        @(negedge clk_50M);
        idle_line(5);
        rst_n = 1'b1;
        idle_line(2 * CPB);
        check("midrst_no_strobe", pulse_cnt - p0, 32'd0);
        model_frame(8'h81, 1'b1);
        send_frame(8'h81, CPB, 1'b1);
        settle("after_rst");
        check("after_rst_data", {24'd0, rx_data}, 32'h0000_0081);

        // ---- randomized frames against the model ----
        for (int n = 0; n < 50; n++) begin
            logic [7:0] d;
            logic       s;
            int         pp;
            int         g;
            d  = 8'($urandom_range(0, 255));
            pp = int'($urandom_range(62, 66));
            s  = ($urandom_range(0, 7) != 0);
            g  = s ? int'($urandom_range(0, 10)) : int'($urandom_range(4, 20));
            model_frame(d, s);
            send_frame(d, pp, s);
            idle_line(g);
        end
        settle("random");
        check("random_data", {24'd0, rx_data}, {24'd0, last_good});
        check("total_strobes", pulse_cnt, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
